// File: rtl/spi_xfer_sched_pkg.sv
// Shared constants for the SPI transfer scheduler: core register map, status bits,
// scheduler/poller state encodings and the timeout default (SPI_XFER_TIMEOUT_EN).
package spi_xfer_sched_pkg;

  localparam logic [2:0] ADDR_RXDATA = 3'd0;
  localparam logic [2:0] ADDR_TXDATA = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_SSMASK = 3'd4;

  localparam logic [2:0] BIT_TRDY = 3'd4;
  localparam logic [2:0] BIT_RRDY = 3'd3;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SET_SS = 4'd1;
  localparam logic [3:0] ST_POLL_T = 4'd2;
  localparam logic [3:0] ST_WR_TX  = 4'd3;
  localparam logic [3:0] ST_POLL_R = 4'd4;
  localparam logic [3:0] ST_RD_RX  = 4'd5;
  localparam logic [3:0] ST_RD_CAP = 4'd6;
  localparam logic [3:0] ST_RSP    = 4'd7;
  localparam logic [3:0] ST_CLR_SS = 4'd8;

  localparam logic [1:0] PH_STROBE  = 2'd0;
  localparam logic [1:0] PH_CAPTURE = 2'd1;
  localparam logic [1:0] PH_GAP     = 2'd2;

  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/spi_xfer_sched_poller.sv
// Status poller shared by both poll states: strobe STATUS, test the selected bit
// on the capture cycle, then idle POLL_GAP cycles before the next strobe.
module spi_status_poller
  import spi_xfer_sched_pkg::*;
#(
  parameter int POLL_GAP = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] bit_sel,
  input  logic [7:0] rdata,
  output logic       rx_en,
  output logic       hit
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  logic [1:0]    phase_reg;
  logic [GW-1:0] gap_cnt_reg;

  assign rx_en = enable && (phase_reg == PH_STROBE);
  assign hit   = enable && (phase_reg == PH_CAPTURE) && rdata[bit_sel];

  // Dropping enable parks the poller so the next poll state strobes on its first cycle.
  always_ff @(posedge clk_in) begin
    if (rst || !enable) begin
      phase_reg   <= PH_STROBE;
      gap_cnt_reg <= '0;
    end else begin
      case (phase_reg)
        PH_STROBE: phase_reg <= PH_CAPTURE;
        PH_CAPTURE: begin
          if (hit || POLL_GAP == 0) begin
            phase_reg <= PH_STROBE;
          end else begin
            phase_reg   <= PH_GAP;
            gap_cnt_reg <= '0;
          end
        end
        PH_GAP: begin
          if (gap_cnt_reg == GW'(POLL_GAP - 1)) phase_reg <= PH_STROBE;
          else gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: phase_reg <= PH_STROBE;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Byte-transfer scheduler driving the SPI master core register port.
// Optional bounded polling with sticky err output: define SPI_XFER_TIMEOUT_EN.
module spi_xfer_sched
  import spi_xfer_sched_pkg::*;
#(
  parameter int IONUM    = 1,
  parameter int POLL_GAP = 2
`ifdef SPI_XFER_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_data,
  input  logic [IONUM-1:0] req_cs,
  input  logic             req_last,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic             spi_tx_en,
  output logic [2:0]       spi_waddr,
  output logic [7:0]       spi_wdata,
  output logic             spi_rx_en,
  output logic [2:0]       spi_raddr,
  input  logic [7:0]       spi_rdata
`ifdef SPI_XFER_TIMEOUT_EN
  , output logic           err
`endif
);

  logic [3:0]       state_reg, state_next;
  logic [7:0]       data_reg;
  logic [IONUM-1:0] cs_reg, cur_cs_reg;
  logic             last_reg, cs_held_reg;
  logic             rsp_valid_reg;
  logic [7:0]       rsp_data_reg;
  logic [7:0]       cs_ext;
  logic             hs, poll_en, poll_rx_en, poll_hit, expired;

  assign busy      = (state_reg != ST_IDLE);
  assign req_ready = !rst && (state_reg == ST_IDLE) && !rsp_valid_reg;
  assign hs        = req_valid && req_ready;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign poll_en   = (state_reg == ST_POLL_T) || (state_reg == ST_POLL_R);

  spi_status_poller #(.POLL_GAP(POLL_GAP)) poller (
    .clk_in  (clk_in),
    .rst     (rst),
    .enable  (poll_en),
    .bit_sel ((state_reg == ST_POLL_T) ? BIT_TRDY : BIT_RRDY),
    .rdata   (spi_rdata),
    .rx_en   (poll_rx_en),
    .hit     (poll_hit)
  );

`ifdef SPI_XFER_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        err_reg;

  // Counter is zero in every non-poll state, so it restarts on each poll-state entry.
  assign expired = poll_en && !poll_hit && (tmo_cnt_reg == 16'(TIMEOUT - 1));
  assign err     = err_reg;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      tmo_cnt_reg <= poll_en ? tmo_cnt_reg + 16'd1 : 16'd0;
      if (hs) err_reg <= 1'b0;
      else if (expired) err_reg <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    cs_ext = '0;
    cs_ext[IONUM-1:0] = cs_reg;
  end

  always_comb begin
    spi_tx_en = 1'b0;
    spi_waddr = 3'd0;
    spi_wdata = 8'd0;
    spi_rx_en = poll_rx_en || (state_reg == ST_RD_RX);
    spi_raddr = (state_reg == ST_RD_RX) ? ADDR_RXDATA :
                (poll_rx_en ? ADDR_STATUS : 3'd0);
    case (state_reg)
      ST_SET_SS: begin spi_tx_en = 1'b1; spi_waddr = ADDR_SSMASK; spi_wdata = cs_ext; end
      ST_WR_TX:  begin spi_tx_en = 1'b1; spi_waddr = ADDR_TXDATA; spi_wdata = data_reg; end
      ST_CLR_SS: begin spi_tx_en = 1'b1; spi_waddr = ADDR_SSMASK; end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (hs) state_next = (cs_held_reg && req_cs == cur_cs_reg) ? ST_POLL_T : ST_SET_SS;
      ST_SET_SS: state_next = ST_POLL_T;
      ST_POLL_T: if (poll_hit) state_next = ST_WR_TX; else if (expired) state_next = ST_CLR_SS;
      ST_WR_TX:  state_next = ST_POLL_R;
      ST_POLL_R: if (poll_hit) state_next = ST_RD_RX; else if (expired) state_next = ST_CLR_SS;
      ST_RD_RX:  state_next = ST_RD_CAP;
      ST_RD_CAP: state_next = ST_RSP;
      ST_RSP:    if (rsp_ready) state_next = last_reg ? ST_CLR_SS : ST_IDLE;
      ST_CLR_SS: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      data_reg      <= '0;
      cs_reg        <= '0;
      cur_cs_reg    <= '0;
      last_reg      <= 1'b0;
      cs_held_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (rsp_valid_reg && rsp_ready) rsp_valid_reg <= 1'b0;
      if (hs) begin
        data_reg <= req_data;
        cs_reg   <= req_cs;
        last_reg <= req_last;
      end
      if (state_reg == ST_SET_SS) cur_cs_reg <= cs_reg;
      if (state_reg == ST_RD_CAP) begin
        rsp_data_reg  <= spi_rdata;
        rsp_valid_reg <= 1'b1;
      end
      if (state_reg == ST_RSP && rsp_ready && !last_reg) cs_held_reg <= 1'b1;
      if (state_reg == ST_CLR_SS) begin
        cs_held_reg <= 1'b0;
        cur_cs_reg  <= '0;
      end
      // A poll that never completes still produces a response, flagged by 8'hFF.
      if (expired) begin
        rsp_data_reg  <= 8'hFF;
        rsp_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a behavioural SPI core model and bus/response
// scoreboards; the timeout case runs only when SPI_XFER_TIMEOUT_EN is defined.
module tb_spi_xfer_sched;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_data = 8'h00;
  logic [0:0] req_cs = 1'b0;
  logic       req_last = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       busy;
  logic       spi_tx_en;
  logic [2:0] spi_waddr;
  logic [7:0] spi_wdata;
  logic       spi_rx_en;
  logic [2:0] spi_raddr;
  logic [7:0] spi_rdata = 8'h00;
`ifdef SPI_XFER_TIMEOUT_EN
  logic       err;
`endif

  always #5 clk_in = ~clk_in;

  spi_xfer_sched #(
    .IONUM(1),
    .POLL_GAP(2)
`ifdef SPI_XFER_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk_in(clk_in), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_cs(req_cs), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .spi_tx_en(spi_tx_en), .spi_waddr(spi_waddr), .spi_wdata(spi_wdata),
    .spi_rx_en(spi_rx_en), .spi_raddr(spi_raddr), .spi_rdata(spi_rdata)
`ifdef SPI_XFER_TIMEOUT_EN
    , .err(err)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [11:0] exp_bus[$];
  logic [7:0]  exp_rsp[$];
  int  stat_cyc[$];
  int  hs_cyc, rsp_cyc;
  bit  hs_seen, rsp_seen, prev_rsp_valid;
  bit  prev_rx;
  logic [2:0] prev_raddr;
  // core model state
  int  trdy_miss, rrdy_miss;
  bit  tx_written, lax_status;
  logic [7:0] rx_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_w(input logic [2:0] a, input logic [7:0] d);
    exp_bus.push_back({1'b1, a, d});
  endtask

  task automatic push_r(input logic [2:0] a);
    exp_bus.push_back({1'b0, a, 8'h00});
  endtask

  // one transfer body after any SSMASK write: poll, TX write, poll, RX read
  task automatic push_body(input logic [7:0] d, input logic [7:0] rx);
    push_r(3'd2); push_w(3'd1, d); push_r(3'd2); push_r(3'd0);
    exp_rsp.push_back(rx);
  endtask

  task automatic tick();
    logic hs_now;
    logic [11:0] ev;
    hs_now = req_valid && req_ready;
    @(posedge clk_in);
    #1;
    cyc++;
    if (hs_now) begin hs_seen = 1; hs_cyc = cyc; end
    // core returns read data the cycle after the strobe
    spi_rdata = 8'h00;
    if (prev_rx && prev_raddr == 3'd2) begin
      if (!tx_written) begin
        spi_rdata = (trdy_miss == 0) ? 8'h10 : 8'h00;
        if (trdy_miss > 0) trdy_miss--;
      end else begin
        spi_rdata = (rrdy_miss == 0) ? 8'h08 : 8'h00;
        if (rrdy_miss > 0) rrdy_miss--;
      end
    end else if (prev_rx && prev_raddr == 3'd0) begin
      spi_rdata = rx_byte;
      tx_written = 0;
    end
    if (spi_tx_en || spi_rx_en) begin
      ev = {spi_tx_en, spi_tx_en ? spi_waddr : spi_raddr, spi_tx_en ? spi_wdata : 8'h00};
      if (spi_tx_en && spi_waddr == 3'd1) tx_written = 1;
      if (spi_rx_en && spi_raddr == 3'd2) stat_cyc.push_back(cyc);
      if (!(lax_status && !spi_tx_en && spi_raddr == 3'd2)) begin
        if (exp_bus.size() == 0) chk("bus_unexpected", {20'd0, ev}, 32'hFFF);
        else chk("bus_op", {20'd0, ev}, {20'd0, exp_bus.pop_front()});
      end
      chk("tx_rx_excl", {31'd0, spi_tx_en & spi_rx_en}, 32'd0);
    end
    prev_rx = spi_rx_en;
    prev_raddr = spi_raddr;
    if (rsp_valid && !prev_rsp_valid) begin
      rsp_seen = 1;
      rsp_cyc = cyc;
      if (exp_rsp.size() == 0) chk("rsp_unexpected", {23'd0, 1'b0, rsp_data}, 32'h100);
      else chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp.pop_front()});
    end
    prev_rsp_valid = rsp_valid;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic c, input logic l);
    req_data = d; req_cs = c; req_last = l; req_valid = 1'b1;
    hs_seen = 0; rsp_seen = 0;
    for (int i = 0; i < 40 && !hs_seen; i++) tick();
    req_valid = 1'b0;
    chk("req_accept", {31'd0, hs_seen}, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300 && !rsp_seen; i++) tick();
    chk("rsp_arrived", {31'd0, rsp_seen}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {8'd0, req_ready, rsp_valid, rsp_data, busy, spi_tx_en, spi_waddr,
              spi_wdata, spi_rx_en, spi_raddr}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // reset state
    rst = 1'b1;
    flush(2);
    chk_idle_outputs("reset_outputs");
    rst = 1'b0;
    tick();
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // single byte, SS write, latency 8
    rx_byte = 8'h3C;
    push_w(3'd4, 8'h01); push_body(8'hA5, 8'h3C); push_w(3'd4, 8'h00);
    send(8'hA5, 1'b1, 1'b1);
    wait_rsp();
    chk("latency_ss", rsp_cyc - hs_cyc, 32'd8);
    flush(3);
    chk("drain_single", exp_bus.size(), 32'd0);

    // burst of three, SSMASK written once, latency 7 for held cs
    push_w(3'd4, 8'h01);
    push_body(8'h11, 8'hEE); push_body(8'h22, 8'hDD); push_body(8'h33, 8'hCC);
    push_w(3'd4, 8'h00);
    rx_byte = 8'hEE; send(8'h11, 1'b1, 1'b0); wait_rsp();
    rx_byte = 8'hDD; send(8'h22, 1'b1, 1'b0); wait_rsp();
    chk("latency_held", rsp_cyc - hs_cyc, 32'd7);
    rx_byte = 8'hCC; send(8'h33, 1'b1, 1'b1); wait_rsp();
    flush(3);
    chk("drain_burst", exp_bus.size(), 32'd0);

    // cs change while held goes straight to the new mask (0 = no-select)
    push_w(3'd4, 8'h01); push_body(8'h44, 8'h55);
    push_w(3'd4, 8'h00); push_body(8'h66, 8'h77); push_w(3'd4, 8'h00);
    rx_byte = 8'h55; send(8'h44, 1'b1, 1'b0); wait_rsp();
    rx_byte = 8'h77; send(8'h66, 1'b0, 1'b1); wait_rsp();
    flush(3);
    chk("drain_cs_change", exp_bus.size(), 32'd0);

    // slow core: 6 status reads 4 cycles apart before the TX write
    trdy_miss = 5;
    stat_cyc.delete();
    push_w(3'd4, 8'h01);
    for (int i = 0; i < 5; i++) push_r(3'd2);
    push_body(8'h5C, 8'h81); push_w(3'd4, 8'h00);
    rx_byte = 8'h81; send(8'h5C, 1'b1, 1'b1); wait_rsp();
    flush(3);
    chk("drain_slow", exp_bus.size(), 32'd0);
    for (int i = 1; i < 6; i++) chk("poll_spacing", stat_cyc[i] - stat_cyc[i-1], 32'd4);

    // backpressure: response held, no acceptance, no bus activity
    rsp_ready = 1'b0;
    push_w(3'd4, 8'h01); push_body(8'hC3, 8'h99);
    rx_byte = 8'h99; send(8'hC3, 1'b1, 1'b1); wait_rsp();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {24'd0, rsp_data}, 32'h99);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    push_w(3'd4, 8'h00);
    rsp_ready = 1'b1;
    flush(4);
    chk("drain_bp", exp_bus.size(), 32'd0);

    // reset during POLL_R, with cs held beforehand
    push_w(3'd4, 8'h01); push_body(8'h5A, 8'h5A);
    rx_byte = 8'h5A; send(8'h5A, 1'b1, 1'b0); wait_rsp();
    flush(2);
    rrdy_miss = 1000; lax_status = 1;
    push_w(3'd1, 8'h6B);
    send(8'h6B, 1'b1, 1'b0);
    for (int i = 0; i < 30 && !tx_written; i++) tick();
    flush(3);
    chk("reached_poll_r", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk_idle_outputs("midreset_outputs");
    chk("drain_pre_reset", exp_bus.size(), 32'd0);
    rst = 1'b0;
    rrdy_miss = 0; trdy_miss = 0; tx_written = 0; lax_status = 0;
    exp_rsp.delete();
    tick();
    push_w(3'd4, 8'h01); push_body(8'h77, 8'h1E); push_w(3'd4, 8'h00);
    rx_byte = 8'h1E; send(8'h77, 1'b1, 1'b1); wait_rsp();
    flush(3);
    chk("drain_after_reset", exp_bus.size(), 32'd0);

`ifdef SPI_XFER_TIMEOUT_EN
    // RRDY never arrives: timeout clears SS, reports FF and sets err
    chk("err_initial", {31'd0, err}, 32'd0);
    rrdy_miss = 1000; lax_status = 1;
    push_w(3'd4, 8'h01); push_w(3'd1, 8'hE7); push_w(3'd4, 8'h00);
    exp_rsp.push_back(8'hFF);
    send(8'hE7, 1'b1, 1'b1); wait_rsp();
    chk("err_set", {31'd0, err}, 32'd1);
    flush(3);
    chk("drain_timeout", exp_bus.size(), 32'd0);
    chk("err_sticky", {31'd0, err}, 32'd1);
    rrdy_miss = 0; tx_written = 0; lax_status = 0;
    push_w(3'd4, 8'h01); push_body(8'h12, 8'h34); push_w(3'd4, 8'h00);
    rx_byte = 8'h34; send(8'h12, 1'b1, 1'b1);
    chk("err_cleared", {31'd0, err}, 32'd0);
    wait_rsp();
    flush(3);
    chk("drain_post_timeout", exp_bus.size(), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sched.md
Name: spi_xfer_sched

Overview:
- Byte-level transaction scheduler in front of the SPI master core's 3-bit-addressed, 8-bit register interface.
- Accepts one byte-transfer request at a time from the CPU-side IO decoder and sequences the core's register accesses: slave-select mask, status poll, TX write, RX read.
- Returns the received byte over a valid/ready response channel.
- Removes all polling from software; the SPI port's bus side drives this block instead of the raw core.

Parameters:
IONUM, 1, number of chip-select lines; width of the SSMASK value and of req_cs.
POLL_GAP, 2, idle cycles between consecutive status polls (0 = back-to-back).

Ports:
clk_in  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_data  in  8  byte to transmit
req_cs  in  IONUM  one-hot slave select for this byte
req_last  in  1  release slave select after this byte
rsp_valid  out  1  received byte available
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  received byte
busy  out  1  high in every state except IDLE
spi_tx_en  out  1  core register write strobe
spi_waddr  out  3  core write address
spi_wdata  out  8  core write data
spi_rx_en  out  1  core register read strobe
spi_raddr  out  3  core read address
spi_rdata  in  8  core read data, valid the cycle after spi_rx_en

Behaviour:
- Reset: all outputs 0, state IDLE, cs_held=0, cur_cs=0. Reset mid-transfer abandons the sequence with no SSMASK clear; the core is reset in parallel.
- req_ready=1 only in IDLE with rsp_valid=0. On handshake, latch data/cs/last.
- States:
  - IDLE: wait for the request handshake.
  - SET_SS: one-cycle write of req_cs to SSMASK (addr 4). Skipped if cs_held=1 and req_cs==cur_cs. Updates cur_cs.
  - POLL_T: spi_rx_en=1, raddr=STATUS (2) for one cycle, then one capture cycle. If TRDY (bit 4) is set, go to WR_TX; otherwise wait POLL_GAP cycles and repoll.
  - WR_TX: one-cycle write of the latched byte to TXDATA (1).
  - POLL_R: same poll pattern, waiting on RRDY (bit 3).
  - RD_RX: read RXDATA (0); capture into rsp_data the next cycle and set rsp_valid.
  - RSP: hold rsp_valid/rsp_data until rsp_ready.
    - If last=1, go to CLR_SS.
    - Else set cs_held=1 and go to IDLE.
  - CLR_SS: write 0 to SSMASK, clear cs_held, go to IDLE.
- spi_tx_en and spi_rx_en are never high in the same cycle. Outside write states, spi_waddr/spi_wdata=0.
- Minimum latency, request handshake to rsp_valid, with immediate TRDY/RRDY and SS write needed: 1 (SET_SS) + 2 (POLL_T) + 1 (WR_TX) + 2 (POLL_R) + 2 (RD_RX) = 8 cycles. With SS skipped: 7.
- cs change while held: SET_SS writes the new mask directly; no intermediate clear.
- req_cs=0: a legal "no-select" transfer. SSMASK is written 0 and the clock still runs.
- rsp_ready held high: response consumed the cycle rsp_valid rises; the next request is accepted no earlier than the following cycle.

Optional Feature:
- Macro: SPI_XFER_TIMEOUT_EN.
- Enabled:
  - Parameter TIMEOUT (default 1024) and output err (1 bit, sticky) are added; err is cleared only by rst or by the next accepted request.
  - A 16-bit counter runs during POLL_T/POLL_R and reloads on entering each poll state.
  - Expiry jumps to CLR_SS, sets err, and presents rsp_valid with rsp_data=8'hFF.
- Disabled: no counter, no err port, and polling is unbounded.

Decomposition:
- Shared package/header: register addresses (RXDATA 0, TXDATA 1, STATUS 2, CTRL 3, SSMASK 4), status bit indices (TRDY 4, RRDY 3), state encoding, timeout default.
- One sub-module, spi_status_poller: issues the read strobe, applies the gap, and returns hit when a masked bit is set. It is instantiated once and shared by POLL_T/POLL_R by selecting the bit.

Test Plan:
1. Single byte: req_data=8'hA5, cs=1, last=1; model returns TRDY/RRDY immediately, RX=8'h3C -> bus sequence W4=01, R2, W1=A5, R2, R0, W4=00; rsp_data=8'h3C exactly 8 cycles after handshake.
2. Burst of 3 bytes (0x11, 0x22, 0x33), same cs, last on the third -> SSMASK written once at start and cleared once at end; three responses in order.
3. Slow core: TRDY false for 5 polls, POLL_GAP=2 -> 6 status reads spaced 4 cycles apart, then the TX write; no TX before TRDY.
4. Backpressure: rsp_ready low for 10 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, no bus activity.
5. Reset asserted during POLL_R -> next cycle: all outputs 0, IDLE; the next request performs a fresh SSMASK write.
6. SPI_XFER_TIMEOUT_EN with TIMEOUT=16, RRDY never set -> err=1, SSMASK=0 written, rsp_data=8'hFF; the next request clears err.
